// File: rtl/lenet_pkg.sv
// ---------------------------------------------------------------------------
// lenet_pkg
// Shared constants and types for the LeNet weight/bias load path.
//   DATA_SIZE          bits per weight or bias byte
//   WORD_BYTES         bytes packed into one weight-RAM word (25 weights + bias)
//   WORD_WIDTH         weight-RAM word width
//   WEIGHT_ADDR_WIDTH  weight-RAM address width
//   WEIGHT_DEPTH       total weight-RAM words (two banks)
//   WEIGHT_BANK_DEPTH  words per bank; bank select lives in the SRAM array
//   loader_state_e     weight_bias_loader FSM states
// ---------------------------------------------------------------------------
package lenet_pkg;

    localparam int DATA_SIZE         = 8;
    localparam int WORD_BYTES        = 26;
    localparam int WORD_WIDTH        = WORD_BYTES * DATA_SIZE;
    localparam int WEIGHT_ADDR_WIDTH = 11;
    localparam int WEIGHT_DEPTH      = 1040;
    localparam int WEIGHT_BANK_DEPTH = 520;
    localparam int BYTE_CNT_WIDTH    = 5;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_CHECK = 3'd1,
        LD_FILL  = 3'd2,
        LD_WRITE = 3'd3,
        LD_FIN   = 3'd4
    } loader_state_e;

    // One bit wider than the address so base+count cannot wrap before the compare.
    function automatic logic request_exceeds_depth(
        input logic [WEIGHT_ADDR_WIDTH-1:0] base,
        input logic [WEIGHT_ADDR_WIDTH-1:0] count
    );
        logic [WEIGHT_ADDR_WIDTH:0] end_addr;
        end_addr = {1'b0, base} + {1'b0, count};
        return end_addr > (WEIGHT_ADDR_WIDTH + 1)'(WEIGHT_DEPTH);
    endfunction

endpackage

// File: rtl/weight_word_packer.sv
// ---------------------------------------------------------------------------
// weight_word_packer
// Shift register that assembles WORD_BYTES bytes into one weight-RAM word.
// The first byte of a word ends up in the top byte lane, the last (bias) in
// the bottom lane.
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   clear_i      drop any partial word and restart at byte 0
//   accept_i     a byte is being accepted this cycle
//   byte_i       byte payload
//   word_next_o  word contents including the byte accepted this cycle
//   word_full_o  the byte accepted this cycle completes the word
// ---------------------------------------------------------------------------
module weight_word_packer
    import lenet_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [DATA_SIZE-1:0]  byte_i,
    output logic [WORD_WIDTH-1:0] word_next_o,
    output logic                  word_full_o
);

    logic [WORD_WIDTH-1:0]     word_q, word_d;
    logic [BYTE_CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign word_full_o = accept_i && (cnt_q == BYTE_CNT_WIDTH'(WORD_BYTES - 1));

    // Exposing the post-shift value lets the caller capture the finished word
    // on the same edge the last byte arrives, with no extra cycle.
    assign word_next_o = accept_i ? {word_q[WORD_WIDTH-DATA_SIZE-1:0], byte_i} : word_q;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (accept_i) begin
            word_d = word_next_o;
            cnt_d  = word_full_o ? '0 : cnt_q + BYTE_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/weight_bias_loader.sv
// ---------------------------------------------------------------------------
// weight_bias_loader
// Writes a stream of weight/bias bytes into the weight RAM, one packed word
// per WORD_BYTES bytes, at consecutive addresses from a programmed base.
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle load request (only honoured when idle)
//   base_addr     first word address, captured with start
//   word_count    number of words to load, captured with start
//   s_valid/s_data/s_ready   byte stream input
//   sram_ena/sram_wea/sram_addra/sram_din   weight-RAM write port
//   busy          request in progress
//   done          one-cycle completion pulse
//   err           one-cycle pulse with done when the request is out of range
//   dbg_state     current FSM state
//
// Byte handshake: a byte transfers on a rising edge where s_valid and s_ready
// are both high. s_ready depends only on the FSM state (never on s_valid);
// the source may raise or drop s_valid at any time and must hold s_data
// stable while s_valid is high.
// ---------------------------------------------------------------------------
module weight_bias_loader
    import lenet_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WEIGHT_ADDR_WIDTH-1:0] base_addr,
    input  logic [WEIGHT_ADDR_WIDTH-1:0] word_count,
    input  logic                         s_valid,
    input  logic [DATA_SIZE-1:0]         s_data,
    output logic                         s_ready,
    output logic                         sram_ena,
    output logic                         sram_wea,
    output logic [WEIGHT_ADDR_WIDTH-1:0] sram_addra,
    output logic [WORD_WIDTH-1:0]        sram_din,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output loader_state_e                dbg_state
);

    loader_state_e                state_q, state_d;
    logic [WEIGHT_ADDR_WIDTH-1:0] base_q, base_d;
    logic [WEIGHT_ADDR_WIDTH-1:0] count_q, count_d;
    logic [WEIGHT_ADDR_WIDTH-1:0] written_q, written_d;

    logic                         s_ready_q, s_ready_d;
    logic                         ena_q, ena_d;
    logic [WEIGHT_ADDR_WIDTH-1:0] addra_q, addra_d;
    logic [WORD_WIDTH-1:0]        din_q, din_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;

    logic                         byte_accept;
    logic                         word_full;
    logic [WORD_WIDTH-1:0]        word_next;

    assign byte_accept = s_valid && s_ready_q;

    weight_word_packer u_packer (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (state_q == LD_CHECK),
        .accept_i    (byte_accept),
        .byte_i      (s_data),
        .word_next_o (word_next),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        written_d = written_q;
        addra_d   = addra_q;
        din_d     = din_q;
        err_d     = 1'b0;

        unique case (state_q)
            LD_IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    count_d   = word_count;
                    written_d = '0;
                    state_d   = LD_CHECK;
                end
            end
            LD_CHECK: begin
                if (count_q == '0) begin
                    state_d = LD_FIN;
                end else if (request_exceeds_depth(base_q, count_q)) begin
                    state_d = LD_FIN;
                    err_d   = 1'b1;
                end else begin
                    state_d = LD_FILL;
                end
            end
            LD_FILL: begin
                // Address and data are captured as the last byte lands so
                // they are already on the port during the WRITE cycle.
                if (word_full) begin
                    addra_d = base_q + written_q;
                    din_d   = word_next;
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                written_d = written_q + WEIGHT_ADDR_WIDTH'(1);
                state_d   = (written_d == count_q) ? LD_FIN : LD_FILL;
            end
            LD_FIN: begin
                state_d = LD_IDLE;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase

        // Flag outputs are registered from the next state so each one is
        // high exactly while the FSM sits in the matching state.
        s_ready_d = (state_d == LD_FILL);
        ena_d     = (state_d == LD_WRITE);
        busy_d    = (state_d != LD_IDLE);
        done_d    = (state_d == LD_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LD_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            written_q <= '0;
            s_ready_q <= 1'b0;
            ena_q     <= 1'b0;
            addra_q   <= '0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            written_q <= written_d;
            s_ready_q <= s_ready_d;
            ena_q     <= ena_d;
            addra_q   <= addra_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign sram_ena   = ena_q;
    assign sram_wea   = ena_q;
    assign sram_addra = addra_q;
    assign sram_din   = din_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_weight_bias_loader.sv
module tb_weight_bias_loader;

    localparam int BYTES_PER_WORD = 26;
    localparam int WW             = 208;
    localparam int AW             = 11;
    localparam int RAM_WORDS      = 1040;
    localparam int BUDGET         = 4000;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] word_count;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          sram_ena;
    logic          sram_wea;
    logic [AW-1:0] sram_addra;
    logic [WW-1:0] sram_din;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;

    weight_bias_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .sram_ena   (sram_ena),
        .sram_wea   (sram_wea),
        .sram_addra (sram_addra),
        .sram_din   (sram_din),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_addr_q[$];
    logic [WW-1:0] exp_q[$];
    int            checks;
    int            errors;
    int            writes;
    int            done_cnt;
    int            done_cyc;
    logic          done_err;
    logic [WW-1:0] last_din;

    // Word w of a load is simply bytes 26w..26w+25 laid out top lane first.
    function automatic logic [WW-1:0] expected_word(input logic [7:0] bytes[$], input int w);
        logic [WW-1:0] word;
        word = '0;
        for (int j = 0; j < BYTES_PER_WORD; j++)
            word[WW-1-8*j -: 8] = bytes[w*BYTES_PER_WORD + j];
        return word;
    endfunction

    // Called once per falling edge: checks every write against the queue.
    task automatic sample();
        logic [AW-1:0] ea;
        logic [WW-1:0] ed;
        if (sram_ena === 1'b1) begin
            checks++;
            assert (sram_wea === 1'b1) else begin errors++; $error("FAIL wea_with_ena obs=%b exp=1", sram_wea); end
            checks++;
            assert (s_ready === 1'b0) else begin errors++; $error("FAIL ready_in_write obs=%b exp=0", s_ready); end
            checks++;
            assert (exp_q.size() != 0) else begin errors++; $error("FAIL unexpected_write obs_addr=%0d exp=none", sram_addra); end
            if (exp_q.size() != 0) begin
                ea = exp_addr_q.pop_front();
                ed = exp_q.pop_front();
                checks++;
                assert (sram_addra === ea) else begin errors++; $error("FAIL write_addr obs=%0d exp=%0d", sram_addra, ea); end
                checks++;
                assert (sram_din === ed) else begin errors++; $error("FAIL write_din obs=%h exp=%h", sram_din, ed); end
            end
            last_din = sram_din;
            writes++;
        end else begin
            checks++;
            assert (sram_wea === 1'b0) else begin errors++; $error("FAIL wea_without_ena obs=%b exp=0", sram_wea); end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_err = err;
            done_cyc = cyc;
        end else begin
            checks++;
            assert (err === 1'b0) else begin errors++; $error("FAIL err_without_done obs=%b exp=0", err); end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        assert ({s_ready, sram_ena, sram_wea, busy, done, err} === 6'b0)
            else begin errors++; $error("FAIL %s_flags obs=%b exp=000000", tag, {s_ready, sram_ena, sram_wea, busy, done, err}); end
        checks++;
        assert (sram_addra === '0) else begin errors++; $error("FAIL %s_addra obs=%0d exp=0", tag, sram_addra); end
        checks++;
        assert (sram_din === '0) else begin errors++; $error("FAIL %s_din obs=%h exp=0", tag, sram_din); end
    endtask

    // ---------------- driver ----------------
    // mode 0: bytes 1,2,3..   mode 1: byte k = k mod 256   mode 2: random
    // glitch_at: loop cycle at which a stray start with another base is pulsed
    // abort_at: accepted-byte count after which rst is pulsed (-1 = never)
    task automatic run_load(input int base, input int cnt, input int mode, input bit gaps,
                            input int glitch_at, input int abort_at, input bit chk_lat);
        logic [7:0] bq[$];
        int  idx;
        int  d0;
        int  w0;
        int  sc;
        bit  exp_err;
        bit  valid_req;
        bit  acc;

        exp_err   = (base + cnt) > RAM_WORDS;
        valid_req = (cnt != 0) && !exp_err;
        idx       = 0;
        if (valid_req) begin
            for (int k = 0; k < cnt * BYTES_PER_WORD; k++) begin
                case (mode)
                    0:       bq.push_back(8'((k + 1) % 256));
                    1:       bq.push_back(8'(k % 256));
                    default: bq.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            for (int w = 0; w < cnt; w++) begin
                exp_addr_q.push_back(AW'(base + w));
                exp_q.push_back(expected_word(bq, w));
            end
        end

        start      = 1'b1;
        base_addr  = AW'(base);
        word_count = AW'(cnt);
        d0 = done_cnt;
        w0 = writes;
        sc = cyc;
        tick();
        start      = 1'b0;
        base_addr  = AW'($urandom_range(0, 2047));
        word_count = AW'($urandom_range(0, 2047));

        for (int c = 0; c < BUDGET && done_cnt == d0; c++) begin
            if (idx < bq.size()) begin
                s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                s_data  = bq[idx];
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom_range(0, 255));
            end
            if (c == glitch_at) begin
                start      = 1'b1;
                base_addr  = 11'd600;
                word_count = 11'd1;
            end else begin
                start = 1'b0;
            end
            // s_ready seen now is what the next rising edge uses.
            acc = s_valid && s_ready;
            tick();
            if (acc) idx++;
            if (abort_at >= 0 && idx == abort_at) begin
                rst     = 1'b1;
                s_valid = 1'b0;
                start   = 1'b0;
                tick();
                check_all_zero("after_abort");
                rst = 1'b0;
                exp_addr_q.delete();
                exp_q.delete();
                return;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;

        checks++;
        assert (done_cnt == d0 + 1) else begin errors++; $error("FAIL done_pulse obs=%0d exp=%0d", done_cnt - d0, 1); end
        checks++;
        assert (done_err === exp_err) else begin errors++; $error("FAIL err_with_done obs=%b exp=%b", done_err, exp_err); end
        checks++;
        assert ((writes - w0) == (valid_req ? cnt : 0))
            else begin errors++; $error("FAIL write_count obs=%0d exp=%0d", writes - w0, valid_req ? cnt : 0); end
        checks++;
        assert (exp_q.size() == 0) else begin errors++; $error("FAIL missing_writes obs=%0d exp=0", exp_q.size()); end
        checks++;
        assert (idx == bq.size()) else begin errors++; $error("FAIL bytes_consumed obs=%0d exp=%0d", idx, bq.size()); end
        if (chk_lat) begin
            // start edge, CHECK, 26 byte edges, WRITE, then done visible: 29 rising edges.
            checks++;
            assert ((done_cyc - sc) == 29) else begin errors++; $error("FAIL done_latency obs=%0d exp=29", done_cyc - sc); end
        end
        tick();
        checks++;
        assert ({busy, done, err} === 3'b000) else begin errors++; $error("FAIL idle_after_done obs=%b exp=000", {busy, done, err}); end
        exp_addr_q.delete();
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int b;
        int n;
        checks     = 0;
        errors     = 0;
        writes     = 0;
        done_cnt   = 0;
        done_cyc   = 0;
        done_err   = 1'b0;
        last_din   = '0;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        s_valid    = 1'b0;
        s_data     = '0;

        repeat (3) tick();
        check_all_zero("reset");
        checks++;
        assert (dbg_state === 3'd0) else begin errors++; $error("FAIL reset_state obs=%0d exp=0", dbg_state); end
        rst = 1'b0;
        tick();

        // single word, bytes 0x01..0x1A back to back
        run_load(0, 1, 0, 1'b0, -1, -1, 1'b1);
        checks++;
        assert (last_din[207:200] === 8'h01) else begin errors++; $error("FAIL first_byte_lane obs=%h exp=01", last_din[207:200]); end
        checks++;
        assert (last_din[7:0] === 8'h1A) else begin errors++; $error("FAIL bias_lane obs=%h exp=1a", last_din[7:0]); end

        // ten words across the 519/520 bank boundary
        run_load(515, 10, 1, 1'b0, -1, -1, 1'b0);

        // random valid gaps
        run_load($urandom_range(0, RAM_WORDS - 3), 3, 2, 1'b1, -1, -1, 1'b0);

        // empty and out-of-range requests, plus both sides of the range edge
        run_load(7, 0, 2, 1'b0, -1, -1, 1'b0);
        run_load(1030, 20, 2, 1'b0, -1, -1, 1'b0);
        run_load(1039, 1, 2, 1'b0, -1, -1, 1'b0);
        run_load(1040, 1, 2, 1'b0, -1, -1, 1'b0);

        // reset 13 bytes into word 2, then a fresh single-word load
        run_load(0, 3, 2, 1'b0, -1, BYTES_PER_WORD + 13, 1'b0);
        run_load(100, 1, 2, 1'b0, -1, -1, 1'b0);

        // stray start while busy must not redirect the load
        run_load(200, 2, 2, 1'b1, 5, -1, 1'b0);

        // a few random requests
        for (int i = 0; i < 3; i++) begin
            n = $urandom_range(1, 4);
            b = $urandom_range(0, RAM_WORDS - n);
            run_load(b, n, 2, 1'($urandom_range(0, 1)), -1, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_bias_loader.md
Name: weight_bias_loader

Overview:
- Initiator/writer for the weights-and-bias SRAM write port of the SRAM array.
- Accepts a byte stream from the off-chip load path over a valid/ready handshake.
- Packs each group of 26 bytes (25 weights + 1 bias) into one 208-bit word and writes the words to consecutive weight-RAM addresses starting at a programmed base.
- Sits between the host/DMA byte interface and the sramArray weight port (ena/wea/addra/din).

Parameters:
- DATA_SIZE, 8, bits per weight/bias byte.
- WORD_BYTES, 26, bytes per SRAM word.
- WORD_WIDTH, 208, SRAM word width (WORD_BYTES*DATA_SIZE).
- ADDR_WIDTH, 11, weight-RAM address width.
- DEPTH, 1040, total weight-RAM words (two 520-word banks).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address, sampled with start.
- word_count  in  ADDR_WIDTH  number of words to load, sampled with start.
- s_valid  in  1  byte valid.
- s_data  in  DATA_SIZE  byte payload.
- s_ready  out  1  loader can accept a byte.
- sram_ena  out  1  weight RAM enable (active-high).
- sram_wea  out  1  weight RAM write enable (active-high).
- sram_addra  out  ADDR_WIDTH  write address.
- sram_din  out  WORD_WIDTH  packed write word.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse; request rejected.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - On rst, all outputs are 0, the FSM goes to IDLE, and the byte counter, word counter and packing register clear.
  - Reset mid-operation discards the partial word; no write is issued in the cycle after reset.
- FSM states: IDLE, CHECK, FILL, WRITE, FIN.
- IDLE:
  - s_ready=0, busy=0.
  - start=1 latches base_addr and word_count and moves to CHECK.
  - start is ignored in every other state.
- CHECK (one cycle, busy=1):
  - If word_count==0, go to FIN; done pulses, no write.
  - Else if base_addr+word_count > DEPTH (12-bit compare), go to FIN with err=1 and done=1 in the same cycle, no write.
  - Else go to FILL.
- FILL:
  - s_ready=1; a byte is accepted when s_valid & s_ready.
  - The first byte of a word lands in [207:200]; each subsequent byte shifts in so the 26th byte lands in [7:0] (bias).
  - When the 26th byte is accepted, move to WRITE.
  - s_valid gaps simply stall; there is no timeout.
- WRITE (exactly one cycle):
  - s_ready=0, sram_ena=1, sram_wea=1, sram_addra=base+words_written, sram_din=packed word.
  - Then words_written increments. If it equals word_count go to FIN, else go to FILL with the byte count at 0.
- FIN (one cycle): done=1, busy=0 next cycle, return to IDLE.
- Output hold and timing:
  - sram_ena/sram_wea are 0 outside WRITE.
  - sram_addra and sram_din hold their last values between writes.
  - All outputs are registered.
  - Throughput is 27 cycles per word with continuous s_valid.
- Addressing:
  - Addresses increment linearly; crossing 519→520 needs no special handling because bank select belongs to the SRAM array.
  - Address arithmetic is ADDR_WIDTH wide; the range check guarantees no wrap.
- Simultaneous events: rst has priority over start and over every handshake.
- Read traffic: never drives reads; the RAM read path is owned by the compute controller and muxed externally.

Decomposition:
- Shared package (lenet_pkg): DATA_SIZE, WORD_BYTES, WORD_WIDTH, WEIGHT_ADDR_WIDTH=11, WEIGHT_DEPTH=1040, WEIGHT_BANK_DEPTH=520, and the loader state enum.
- One sub-module, weight_word_packer:
  - Shift register plus 5-bit byte counter.
  - Inputs: byte-accept strobe, clear.
  - Output: word_full flag.
  - The FSM and address logic stay in the top module.

Test Plan:
- Single word: base=0, count=1, bytes 0x01..0x1A continuous → exactly one write cycle, addra=0, din[207:200]=0x01, din[7:0]=0x1A, done pulses 27+ cycles after CHECK.
- Bank crossing: base=515, count=10, byte k = k mod 256 → 10 writes at addra 515..524, each din matches its 26-byte slice, no skipped or duplicate address.
- Backpressure and gaps: s_valid toggled randomly with count=3 → s_ready is 0 during each WRITE, no byte lost or duplicated, 3 correct words.
- Degenerate and rejected requests:
  - count=0 → done=1 and err=0, no ena.
  - base=1030, count=20 → err=1 and done=1 same cycle, no ena, busy back to 0.
- Reset mid-fill: rst asserted after 13 bytes of word 2 → all outputs 0 next cycle, no write. A fresh start (base=100, count=1) then writes a word built only from new bytes.
- start pulsed while busy with a different base → ignored; the original sequence completes at its original addresses.
